// File: rtl/perf_monitor.sv
// perf_monitor: saturating cycle/event counters, halt-store detection and a valid/ready dump of a dmem window
module perf_monitor #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W = 32,
  parameter int NEV = 2,
  parameter logic [DATA_W-1:0] HALT_ADDR = 32'h0000_7fff,
  parameter int DUMP_BASE = 100,
  parameter int DUMP_LEN = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NEV-1:0]       ev,
  input  logic [DATA_W-1:0]    daddr,
  input  logic [DATA_W-1:0]    dwdata,
  input  logic                 dwe,
  input  logic                 clr,
  output logic [ADDR_W-1:0]    mon_addr,
  input  logic [DATA_W-1:0]    mon_rdata,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 out_ready,
  output logic                 halted,
  output logic                 done,
  output logic [CNT_W-1:0]     cycles,
  output logic [NEV*CNT_W-1:0] ev_cnt,
  output logic [DATA_W-1:0]    exit_code
);
  typedef enum logic [1:0] {RUN, FETCH, SEND, DONE} state_t;
  localparam int IW = DUMP_LEN < 1 ? 1 : $clog2(DUMP_LEN + 1);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [NEV:0][CNT_W-1:0] cnt;
  logic [NEV:0] inc;
  logic halt_st, last, run, clr_now;
  assign halt_st = dwe && daddr == HALT_ADDR;
  assign last = idx == IW'(DUMP_LEN - 1);
  assign run = state == RUN;
  assign clr_now = clr && (run || state == DONE);
  assign inc = {ev, 1'b1};
  assign mon_addr = ADDR_W'(DUMP_BASE) + ADDR_W'(idx);
  assign out_valid = state == SEND;
  assign halted = !run;
  assign done = state == DONE;
  assign cycles = cnt[0];
  assign ev_cnt = cnt[NEV:1];
  always_comb
    state_nx = run ? (halt_st ? (DUMP_LEN == 0 ? DONE : FETCH) : RUN) :
               state == FETCH ? SEND :
               state == SEND ? (out_ready ? (last ? DONE : FETCH) : SEND) :
               (clr ? RUN : DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      exit_code <= '0;
      out_data <= '0;
    end else begin
      if (clr_now && !run) begin
        idx <= '0;
        exit_code <= '0;
      end else if (run && halt_st) exit_code <= dwdata;
      if (state == SEND && out_ready && !last) idx <= idx + 1'b1;
      if (state == FETCH) out_data <= mon_rdata;
    end
  // slot 0 is the cycle counter (always incrementing), slots 1..NEV follow ev
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else
      for (int k = 0; k <= NEV; k++)
        if (clr_now) cnt[k] <= '0;
        else if (run && !halt_st && inc[k] && !(&cnt[k])) cnt[k] <= cnt[k] + 1'b1;
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: randomized self-checking bench for perf_monitor (main instance plus a 4-bit, zero-length-dump instance)
module tb_perf_monitor;
  localparam logic [31:0] HALT = 32'h0000_7fff;
  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] ev;
  logic [31:0] daddr, dwdata;
  logic dwe, clr, out_ready;
  logic [15:0] a_mon_addr, b_mon_addr;
  logic [31:0] a_mon_rdata, b_mon_rdata, a_out_data, b_out_data, a_exit, b_exit, a_cycles;
  logic a_out_valid, b_out_valid, a_halted, b_halted, a_done, b_done;
  logic [63:0] a_ev_cnt;
  logic [3:0] b_cycles;
  logic [7:0] b_ev_cnt;
  logic [31:0] mem [0:65535];
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  assign a_mon_rdata = mem[a_mon_addr];
  assign b_mon_rdata = mem[b_mon_addr];
  perf_monitor #(.CNT_W(32), .DUMP_BASE(100), .DUMP_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ev(ev), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .clr(clr),
    .mon_addr(a_mon_addr), .mon_rdata(a_mon_rdata), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(out_ready), .halted(a_halted), .done(a_done), .cycles(a_cycles), .ev_cnt(a_ev_cnt),
    .exit_code(a_exit));
  perf_monitor #(.CNT_W(4), .DUMP_BASE(100), .DUMP_LEN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ev(ev), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .clr(clr),
    .mon_addr(b_mon_addr), .mon_rdata(b_mon_rdata), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(out_ready), .halted(b_halted), .done(b_done), .cycles(b_cycles), .ev_cnt(b_ev_cnt),
    .exit_code(b_exit));
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  task tick;
    @(posedge clk);
    #1;
  endtask
  task idle_in;
    ev = 0;
    daddr = 0;
    dwdata = 0;
    dwe = 0;
    clr = 0;
    out_ready = 0;
  endtask
  task restart;
    idle_in;
    clr = 1;
    tick;
    tick;
    clr = 0;
  endtask
  task fill_mem;
    for (int i = 0; i < 4; i++) mem[100 + i] = $urandom;
  endtask
  task test_reset;
    idle_in;
    rst_n = 0;
    tick;
    tick;
    #3;
    n_cmp++; if ({a_out_valid, a_halted, a_done, b_out_valid, b_halted, b_done} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got=%b want=000000", {a_out_valid, a_halted, a_done, b_out_valid, b_halted, b_done}); end
    n_cmp++; if ({a_cycles, a_ev_cnt, a_exit, a_out_data} !== 160'b0) begin n_fail++; $display("FAIL reset_regs got cyc=%0h ev=%0h exit=%0h data=%0h want all 0", a_cycles, a_ev_cnt, a_exit, a_out_data); end
    n_cmp++; if ({b_cycles, b_ev_cnt, b_exit} !== 44'b0) begin n_fail++; $display("FAIL reset_b got cyc=%0h ev=%0h exit=%0h want 0", b_cycles, b_ev_cnt, b_exit); end
    n_cmp++; if (a_mon_addr !== 16'd100) begin n_fail++; $display("FAIL reset_mon_addr got=%0d want=100", a_mon_addr); end
    rst_n = 1;
    tick;
  endtask
  task test_count_basic;
    fill_mem;
    restart;
    for (int i = 0; i < 10; i++) begin
      ev = (i == 1 || i == 4 || i == 7) ? 2'b01 : 2'b00;
      tick;
    end
    ev = 0;
    dwe = 1;
    daddr = HALT;
    dwdata = 32'h1234;
    tick;
    dwe = 0;
    daddr = 0;
    n_cmp++; if (a_cycles !== 32'd10) begin n_fail++; $display("FAIL basic_cycles got=%0d want=10", a_cycles); end
    n_cmp++; if (a_ev_cnt !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL basic_ev got=%h want=%h", a_ev_cnt, {32'd0, 32'd3}); end
    n_cmp++; if (a_exit !== 32'h1234) begin n_fail++; $display("FAIL basic_exit got=%h want=1234", a_exit); end
    n_cmp++; if ({a_halted, a_out_valid, a_done} !== 3'b100) begin n_fail++; $display("FAIL basic_halt_flags got=%b want=100", {a_halted, a_out_valid, a_done}); end
    n_cmp++; if (a_mon_addr !== 16'd100) begin n_fail++; $display("FAIL basic_fetch_addr got=%0d want=100", a_mon_addr); end
    n_cmp++; if ({b_cycles, b_ev_cnt, b_exit} !== {4'd10, 4'd0, 4'd3, 32'h1234}) begin n_fail++; $display("FAIL basic_b got cyc=%0d ev=%h exit=%h", b_cycles, b_ev_cnt, b_exit); end
    n_cmp++; if ({b_halted, b_done, b_out_valid} !== 3'b110) begin n_fail++; $display("FAIL zero_len_done got=%b want=110", {b_halted, b_done, b_out_valid}); end
    tick;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== mem[100]) begin n_fail++; $display("FAIL basic_first_word got v=%b d=%h want v=1 d=%h", a_out_valid, a_out_data, mem[100]); end
  endtask
  task test_dump_backpressure;
    int k;
    logic tog, hold;
    logic [31:0] prev;
    k = 0;
    tog = 0;
    hold = 0;
    prev = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      dwe = cyc == 5;
      daddr = HALT;
      dwdata = 32'hdead_beef;
      if (a_out_valid) begin
        if (hold) begin
          n_cmp++; if (a_out_data !== prev) begin n_fail++; $display("FAIL bp_stable got=%h want=%h", a_out_data, prev); end
        end
        out_ready = tog;
        tog = ~tog;
        if (out_ready) begin
          n_cmp++; if (a_out_data !== mem[100 + k]) begin n_fail++; $display("FAIL bp_word%0d got=%h want=%h", k, a_out_data, mem[100 + k]); end
          k++;
          hold = 0;
        end else begin
          prev = a_out_data;
          hold = 1;
        end
      end else begin
        out_ready = 1'($urandom);
        n_cmp++; if (a_mon_addr !== 16'(100 + k)) begin n_fail++; $display("FAIL bp_mon_addr got=%0d want=%0d", a_mon_addr, 100 + k); end
      end
      n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_len_valid got=%b want=0", b_out_valid); end
      tick;
    end
    idle_in;
    n_cmp++; if (k !== 4) begin n_fail++; $display("FAIL bp_word_count got=%0d want=4", k); end
    n_cmp++; if ({a_done, a_out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_done got done/valid=%b want=10", {a_done, a_out_valid}); end
    n_cmp++; if (a_exit !== 32'h1234 || b_exit !== 32'h1234) begin n_fail++; $display("FAIL second_halt_exit got a=%h b=%h want=1234", a_exit, b_exit); end
    out_ready = 1;
    tick;
    n_cmp++; if ({a_done, a_out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_done_hold got=%b want=10", {a_done, a_out_valid}); end
  endtask
  task test_done_clr;
    clr = 1;
    ev = 2'b11;
    tick;
    idle_in;
    n_cmp++; if ({a_halted, a_done, b_halted, b_done} !== 4'b0) begin n_fail++; $display("FAIL done_clr_flags got=%b want=0000", {a_halted, a_done, b_halted, b_done}); end
    n_cmp++; if ({a_cycles, a_ev_cnt, a_exit} !== 128'b0) begin n_fail++; $display("FAIL done_clr_a got cyc=%0d ev=%h exit=%h want 0", a_cycles, a_ev_cnt, a_exit); end
    n_cmp++; if ({b_cycles, b_ev_cnt, b_exit} !== 44'b0) begin n_fail++; $display("FAIL done_clr_b got cyc=%0d ev=%h exit=%h want 0", b_cycles, b_ev_cnt, b_exit); end
    tick;
    n_cmp++; if (a_cycles !== 32'd1) begin n_fail++; $display("FAIL done_clr_resume got=%0d want=1", a_cycles); end
  endtask
  task test_random_count;
    int n, c0, c1, w;
    logic [31:0] code;
    fill_mem;
    restart;
    n = $urandom_range(8, 30);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < n; i++) begin
      ev = 2'($urandom);
      c0 += ev[0];
      c1 += ev[1];
      case ($urandom_range(0, 3))
        0: begin dwe = 1; daddr = 32'h0001_7fff; end
        1: begin dwe = 0; daddr = HALT; end
        2: begin dwe = 1; daddr = HALT ^ (32'd1 << $urandom_range(0, 31)); end
        default: begin dwe = 0; daddr = $urandom; end
      endcase
      dwdata = $urandom;
      tick;
      n_cmp++; if (a_halted !== 1'b0) begin n_fail++; $display("FAIL near_miss_halt cyc=%0d daddr=%h dwe=%b got=1 want=0", i, daddr, dwe); end
    end
    code = $urandom;
    ev = 2'($urandom);
    dwe = 1;
    daddr = HALT;
    dwdata = code;
    tick;
    idle_in;
    n_cmp++; if ({a_cycles, a_ev_cnt} !== {32'(n), 32'(c1), 32'(c0)}) begin n_fail++; $display("FAIL rand_cnt_a got cyc=%0d ev=%h want cyc=%0d ev1=%0d ev0=%0d", a_cycles, a_ev_cnt, n, c1, c0); end
    n_cmp++; if ({b_cycles, b_ev_cnt} !== {4'(n > 15 ? 15 : n), 4'(c1 > 15 ? 15 : c1), 4'(c0 > 15 ? 15 : c0)}) begin n_fail++; $display("FAIL rand_cnt_b got cyc=%0d ev=%h want n=%0d c1=%0d c0=%0d saturated", b_cycles, b_ev_cnt, n, c1, c0); end
    n_cmp++; if (a_exit !== code || b_exit !== code) begin n_fail++; $display("FAIL rand_exit got a=%h b=%h want=%h", a_exit, b_exit, code); end
    w = 0;
    out_ready = 1;
    for (int s = 0; s < 8; s++) begin
      ev = 2'($urandom);
      if (a_out_valid) begin
        n_cmp++; if (a_out_data !== mem[100 + w]) begin n_fail++; $display("FAIL rand_word%0d got=%h want=%h", w, a_out_data, mem[100 + w]); end
        w++;
      end
      n_cmp++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rand_early_done step=%0d got=1 want=0", s); end
      tick;
    end
    idle_in;
    n_cmp++; if (a_done !== 1'b1 || w !== 4) begin n_fail++; $display("FAIL rand_throughput got done=%b words=%0d want done=1 words=4", a_done, w); end
    n_cmp++; if (a_cycles !== 32'(n) || a_ev_cnt !== {32'(c1), 32'(c0)}) begin n_fail++; $display("FAIL rand_frozen got cyc=%0d ev=%h want cyc=%0d", a_cycles, a_ev_cnt, n); end
  endtask
  task test_clr_with_halt;
    int w;
    logic [31:0] code;
    fill_mem;
    restart;
    ev = 2'b11;
    repeat (3) tick;
    code = $urandom;
    clr = 1;
    dwe = 1;
    daddr = HALT;
    dwdata = code;
    tick;
    idle_in;
    n_cmp++; if ({a_cycles, a_ev_cnt} !== 96'b0) begin n_fail++; $display("FAIL clr_halt_cnt got cyc=%0d ev=%h want 0", a_cycles, a_ev_cnt); end
    n_cmp++; if (a_exit !== code || a_halted !== 1'b1) begin n_fail++; $display("FAIL clr_halt_exit got exit=%h halted=%b want exit=%h halted=1", a_exit, a_halted, code); end
    w = 0;
    out_ready = 1;
    for (int s = 0; s < 8; s++) begin
      ev = 2'b11;
      clr = 1'($urandom);
      if (a_out_valid) begin
        n_cmp++; if (a_out_data !== mem[100 + w]) begin n_fail++; $display("FAIL clr_halt_word%0d got=%h want=%h", w, a_out_data, mem[100 + w]); end
        w++;
      end
      tick;
    end
    idle_in;
    n_cmp++; if (a_done !== 1'b1 || w !== 4) begin n_fail++; $display("FAIL clr_halt_dump got done=%b words=%0d want done=1 words=4", a_done, w); end
    n_cmp++; if ({a_cycles, a_ev_cnt} !== 96'b0) begin n_fail++; $display("FAIL dump_ignores_ev got cyc=%0d ev=%h want 0", a_cycles, a_ev_cnt); end
    restart;
  endtask
  task test_saturation;
    restart;
    ev = 2'b11;
    repeat (20) tick;
    idle_in;
    n_cmp++; if ({b_cycles, b_ev_cnt} !== 12'hfff) begin n_fail++; $display("FAIL sat_b got cyc=%h ev=%h want f/ff", b_cycles, b_ev_cnt); end
    n_cmp++; if ({a_cycles, a_ev_cnt} !== {32'd20, 32'd20, 32'd20}) begin n_fail++; $display("FAIL sat_a got cyc=%0d ev=%h want 20 each", a_cycles, a_ev_cnt); end
  endtask
  task test_reset_mid_dump;
    int n, c0, c1, s;
    fill_mem;
    restart;
    repeat (5) tick;
    dwe = 1;
    daddr = HALT;
    dwdata = $urandom;
    tick;
    idle_in;
    out_ready = 1;
    repeat (3) tick;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== mem[101]) begin n_fail++; $display("FAIL mid_send_word2 got v=%b d=%h want v=1 d=%h", a_out_valid, a_out_data, mem[101]); end
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if ({a_out_valid, a_halted, a_done} !== 3'b0) begin n_fail++; $display("FAIL async_rst_flags got=%b want=000", {a_out_valid, a_halted, a_done}); end
    n_cmp++; if ({a_cycles, a_ev_cnt, a_exit, a_out_data} !== 160'b0 || a_mon_addr !== 16'd100) begin n_fail++; $display("FAIL async_rst_regs got cyc=%0d ev=%h exit=%h data=%h addr=%0d", a_cycles, a_ev_cnt, a_exit, a_out_data, a_mon_addr); end
    #2;
    rst_n = 1;
    n = $urandom_range(3, 10);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < n; i++) begin
      ev = 2'($urandom);
      c0 += ev[0];
      c1 += ev[1];
      tick;
    end
    ev = 0;
    n_cmp++; if ({a_cycles, a_ev_cnt} !== {32'(n), 32'(c1), 32'(c0)}) begin n_fail++; $display("FAIL post_rst_count got cyc=%0d ev=%h want cyc=%0d ev1=%0d ev0=%0d", a_cycles, a_ev_cnt, n, c1, c0); end
    dwe = 1;
    daddr = HALT;
    dwdata = 32'h55;
    tick;
    dwe = 0;
    n_cmp++; if (a_halted !== 1'b1 || a_mon_addr !== 16'd100) begin n_fail++; $display("FAIL post_rst_fetch got halted=%b addr=%0d want 1/100", a_halted, a_mon_addr); end
    tick;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== mem[100]) begin n_fail++; $display("FAIL post_rst_word0 got v=%b d=%h want v=1 d=%h", a_out_valid, a_out_data, mem[100]); end
    for (s = 0; s < 20 && !a_done; s++) tick;
    n_cmp++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL post_rst_done got=%b want=1 within 20 cycles", a_done); end
    idle_in;
  endtask
  initial begin
    idle_in;
    test_reset;
    test_count_basic;
    test_dump_backpressure;
    test_done_clr;
    test_random_count;
    test_clr_with_halt;
    test_saturation;
    test_reset_mid_dump;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable run monitor that sits beside the `mipse` core and `dmem`, replacing bench-only cycle/stall accounting and end-of-run handling. It counts cycles and NEV per-cycle event lines (stall, etc.) with saturating counters. It detects the halt store (write to HALT_ADDR), latches the exit code and freezes the counters. It then streams a DUMP_LEN-word window of data memory out over a valid/ready port.

## Interface
- DATA_W, 32, core data/address width
- ADDR_W, 16, dmem word-address width (dmem indexed by daddr[17:2])
- CNT_W, 32, width of each counter
- NEV, 2, number of event inputs
- HALT_ADDR, 32'h0000_7fff, full-width byte address whose store ends the run
- DUMP_BASE, 100, first dmem word index dumped
- DUMP_LEN, 100, number of words dumped (0 allowed)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ev  in  NEV  event strobes, ev[i] counted each cycle it is 1 while running
- daddr  in  DATA_W  core data address (aluout)
- dwdata  in  DATA_W  core store data
- dwe  in  1  core store enable
- clr  in  1  synchronous counter clear / restart
- mon_addr  out  ADDR_W  dmem monitor-port word address, = DUMP_BASE + idx
- mon_rdata  in  DATA_W  dmem monitor-port read data, combinational from mon_addr
- out_valid  out  1  dump word valid
- out_data  out  DATA_W  dump word
- out_ready  in  1  sink accepts dump word
- halted  out  1  halt store seen; core must stall
- done  out  1  dump complete
- cycles  out  CNT_W  cycle count
- ev_cnt  out  NEV*CNT_W  event counts, counter i at [i*CNT_W +: CNT_W]
- exit_code  out  DATA_W  dwdata of the halt store

## Operation
- States: RUN, FETCH, SEND, DONE. Reset → RUN, idx=0, all counters, exit_code, out_data = 0, out_valid/halted/done = 0.
- Halt store: dwe=1 and daddr==HALT_ADDR (all DATA_W bits).
- RUN:
  - Each cycle without a halt store: cycles+=1, ev_cnt[i]+=ev[i].
  - Counters saturate at all-ones and never wrap.
  - clr=1 zeroes every counter instead of incrementing, and clr has priority.
  - On a halt store: exit_code←dwdata and counters are not incremented, so the halt cycle is excluded. If clr is also 1, counters go to 0.
  - After a halt store, go to FETCH, or to DONE if DUMP_LEN==0.
- FETCH: out_data←mon_rdata; → SEND.
- SEND: out_valid=1, out_data held stable.
  - out_ready=1: word accepted. If idx==DUMP_LEN-1 → DONE, else idx+=1 and → FETCH.
  - out_ready=0: stay in SEND.
- DONE: done=1, out_valid=0.
  - clr=1: counters, exit_code, idx → 0; state → RUN.
- halted=1 in FETCH, SEND, DONE; 0 in RUN.
- Counters are frozen outside RUN; ev and clr are ignored in FETCH/SEND.
- Halt stores outside RUN are ignored; exit_code is not overwritten.
- idx width is ceil(log2(DUMP_LEN+1)). mon_addr = DUMP_BASE + idx truncated to ADDR_W; wraps mod 2^ADDR_W.

## Timing
- Halt store in cycle t → halted=1 and exit_code valid from t+1.
- First out_valid at t+2.
- Each word costs 1 FETCH cycle plus ≥1 SEND cycle. With out_ready held at 1, throughput is 1 word per 2 cycles.
- Last word accepted at edge e → done=1 from e+1.
- mon_addr is valid throughout FETCH. mon_rdata is sampled at the FETCH→SEND edge.
- rst_n low at any point, including mid-dump: all outputs go to reset values immediately, asynchronously. Dump progress is discarded.

## Test plan
- Count basic: ev=2'b01 on 3 of 10 cycles, then halt store (daddr=32'h7fff, dwdata=32'h1234). Expect cycles=10, ev_cnt[0]=3, ev_cnt[1]=0, exit_code=32'h1234, halted=1 next cycle.
- Dump backpressure, DUMP_BASE=100, DUMP_LEN=4, mem[100..103]=A0..A3, out_ready toggling 1,0,1,0…:
  - Expect words A0,A1,A2,A3 in order.
  - out_data is stable while out_ready=0.
  - done=1 one cycle after A3 is accepted; out_valid=0 thereafter.
- Saturation, CNT_W=4: 20 cycles with ev=2'b11, no halt. Expect cycles=ev_cnt[0]=ev_cnt[1]=4'hF.
- Near-miss and boundary stores:
  - daddr=32'h0001_7fff with dwe=1 → no halt.
  - daddr=32'h7fff with dwe=0 → no halt.
  - A second halt store during SEND → exit_code unchanged.
  - DUMP_LEN=0 → halt store leads directly to DONE, out_valid never 1.
- clr interactions:
  - clr with halt store in the same cycle → counters 0, exit_code latched, dump proceeds.
  - clr in DONE → state RUN, all counters 0, halted=0, done=0.
- Reset mid-dump: rst_n low during SEND of word 2 → out_valid, halted, done, counters all 0 immediately. After release, normal counting resumes and a fresh halt restarts the dump at mon_addr=DUMP_BASE.
